// File: rtl/stq_ctrl_pkg.sv
// Shared types and pointer helpers for the store-queue controller.
// Pointers carry one extra wrap bit above the entry index.
package stq_ctrl_pkg;

    localparam int DEPTH = 16;
    localparam int INDEX = 4;
    localparam int WIDTH = 64;

    typedef logic [INDEX:0]   stq_ptr_t;
    typedef logic [INDEX-1:0] stq_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } drain_state_t;

    function automatic stq_ptr_t ptr_inc(input stq_ptr_t p);
        return p + stq_ptr_t'(1);
    endfunction

    function automatic stq_idx_t ptr_idx(input stq_ptr_t p);
        return p[INDEX-1:0];
    endfunction

endpackage

// File: rtl/stq_ctrl_if.sv
// D-cache store request channel: valid/ready request plus a completion ack.
// The STQ controller is the master, the D-cache the slave.
interface stq_ctrl_if
    import stq_ctrl_pkg::*;
();

    logic             dc_req_valid_o;
    logic [WIDTH-1:0] dc_req_data_o;
    logic             dc_req_ready_i;
    logic             dc_ack_i;

    modport master (
        output dc_req_valid_o,
        output dc_req_data_o,
        input  dc_req_ready_i,
        input  dc_ack_i
    );

    modport slave (
        input  dc_req_valid_o,
        input  dc_req_data_o,
        output dc_req_ready_i,
        output dc_ack_i
    );

endinterface

// File: rtl/stq_ptr_ctr.sv
// Wrap-bit pointer register: load has priority over increment.
// Used for the head, commit and tail pointers of the store queue.
module stq_ptr_ctr
    import stq_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     inc,
    input  logic     load,
    input  stq_ptr_t load_val,
    output stq_ptr_t ptr
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr_inc(ptr);
        end
    end

endmodule

// File: rtl/stq_ctrl.sv
// Store-queue controller: allocation, writeback, commit tracking and
// in-order drain of committed stores to the D-cache.
module stq_ctrl
    import stq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req_i,
    output logic             alloc_gnt_o,
    output logic [INDEX-1:0] alloc_id_o,
    input  logic             wr_valid_i,
    input  logic [INDEX-1:0] wr_id_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             ram_we_o,
    output logic [INDEX-1:0] ram_waddr_o,
    output logic [WIDTH-1:0] ram_wdata_o,
    output logic [INDEX-1:0] ram_raddr_o,
    input  logic [WIDTH-1:0] ram_rdata_i,
    input  logic             commit_i,
    input  logic             recover_i,
    input  logic [INDEX:0]   recover_tail_i,
    input  logic             flush_i,
    output logic [INDEX:0]   stq_count_o,
    output logic             stq_full_o,
    output logic             stq_empty_o,
    stq_ctrl_if.master       dc
);

    stq_ptr_t         head;
    stq_ptr_t         cmt;
    stq_ptr_t         tail;
    stq_ptr_t         cmt_nxt;
    stq_ptr_t         tail_ld_val;
    logic             full;
    logic             cmt_inc;
    logic             head_inc;
    logic             tail_ld;
    logic [DEPTH-1:0] ready;
    drain_state_t     state;

    assign full = (ptr_idx(head) == ptr_idx(tail)) &&
                  (head[INDEX] != tail[INDEX]);

    assign stq_full_o  = full;
    assign stq_empty_o = (head == tail);
    assign stq_count_o = tail - head;

    assign alloc_gnt_o = alloc_req_i & ~full & ~recover_i & ~flush_i;
    assign alloc_id_o  = ptr_idx(tail);
    assign ram_raddr_o = ptr_idx(head);

    // Flush restores the tail to the commit point after this cycle's commit.
    assign cmt_inc     = commit_i && (cmt != tail);
    assign cmt_nxt     = cmt_inc ? ptr_inc(cmt) : cmt;
    assign tail_ld     = flush_i | recover_i;
    assign tail_ld_val = flush_i ? cmt_nxt : stq_ptr_t'(recover_tail_i);
    assign head_inc    = (state == WAIT) && dc.dc_ack_i;

    stq_ptr_ctr u_head (
        .clk      (clk),
        .reset    (reset),
        .inc      (head_inc),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (head)
    );

    stq_ptr_ctr u_cmt (
        .clk      (clk),
        .reset    (reset),
        .inc      (cmt_inc),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (cmt)
    );

    stq_ptr_ctr u_tail (
        .clk      (clk),
        .reset    (reset),
        .inc      (alloc_gnt_o),
        .load     (tail_ld),
        .load_val (tail_ld_val),
        .ptr      (tail)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_we_o    <= 1'b0;
            ram_waddr_o <= '0;
            ram_wdata_o <= '0;
        end else begin
            ram_we_o <= wr_valid_i;
            if (wr_valid_i) begin
                ram_waddr_o <= wr_id_i;
                ram_wdata_o <= wr_data_i;
            end
        end
    end

    // A late writeback to the same slot wins over the clears.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready <= '0;
        end else begin
            if (alloc_gnt_o) ready[ptr_idx(tail)] <= 1'b0;
            if (head_inc)    ready[ptr_idx(head)] <= 1'b0;
            if (wr_valid_i)  ready[wr_id_i]       <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            dc.dc_req_valid_o <= 1'b0;
            dc.dc_req_data_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if ((head != cmt) && ready[ptr_idx(head)]) begin
                        state             <= SEND;
                        dc.dc_req_valid_o <= 1'b1;
                        dc.dc_req_data_o  <= ram_rdata_i;
                    end
                end
                SEND: begin
                    if (dc.dc_req_ready_i) begin
                        state             <= WAIT;
                        dc.dc_req_valid_o <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dc.dc_ack_i) state <= IDLE;
                end
                default: begin
                    state             <= IDLE;
                    dc.dc_req_valid_o <= 1'b0;
                end
            endcase
        end
    end

    recover_range_a: assert property (
        @(posedge clk) disable iff (!reset)
        (recover_i && !flush_i) |->
            (stq_ptr_t'(recover_tail_i - cmt) <= stq_ptr_t'(tail - cmt))
    );

endmodule

// File: tb/tb_stq_ctrl.sv
// Directed and randomized bench for stq_ctrl against an occupancy-level
// model built on absolute (unwrapped) sequence numbers.
module tb_stq_ctrl;
    import stq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_req_i;
    logic        alloc_gnt_o;
    logic [3:0]  alloc_id_o;
    logic        wr_valid_i;
    logic [3:0]  wr_id_i;
    logic [63:0] wr_data_i;
    logic        ram_we_o;
    logic [3:0]  ram_waddr_o;
    logic [63:0] ram_wdata_o;
    logic [3:0]  ram_raddr_o;
    logic [63:0] ram_rdata_i;
    logic        commit_i;
    logic        recover_i;
    logic [4:0]  recover_tail_i;
    logic        flush_i;
    logic [4:0]  stq_count_o;
    logic        stq_full_o;
    logic        stq_empty_o;

    stq_ctrl_if dc();

    stq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req_i    (alloc_req_i),
        .alloc_gnt_o    (alloc_gnt_o),
        .alloc_id_o     (alloc_id_o),
        .wr_valid_i     (wr_valid_i),
        .wr_id_i        (wr_id_i),
        .wr_data_i      (wr_data_i),
        .ram_we_o       (ram_we_o),
        .ram_waddr_o    (ram_waddr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_raddr_o    (ram_raddr_o),
        .ram_rdata_i    (ram_rdata_i),
        .commit_i       (commit_i),
        .recover_i      (recover_i),
        .recover_tail_i (recover_tail_i),
        .flush_i        (flush_i),
        .stq_count_o    (stq_count_o),
        .stq_full_o     (stq_full_o),
        .stq_empty_o    (stq_empty_o),
        .dc             (dc)
    );

    always #5 clk = ~clk;

    // STQ RAM stand-in; a write in flight is visible on the read port.
    logic [63:0] mem [16];
    always @(posedge clk) if (ram_we_o) mem[ram_waddr_o] <= ram_wdata_o;
    assign ram_rdata_i = (ram_we_o && ram_waddr_o == ram_raddr_o)
                       ? ram_wdata_o : mem[ram_raddr_o];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: absolute sequence numbers for head/commit/tail.
    int          hd, cm, tl;
    int          dph;
    logic [63:0] dexp;
    bit          rdy [16];
    logic [63:0] pay [16];
    bit          m_we;
    logic [3:0]  m_waddr;
    logic [63:0] m_wdata;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_gnt();
        return alloc_req_i && (tl - hd) != 16 && !recover_i && !flush_i;
    endfunction

    task automatic check_all();
        chk("count", stq_count_o, 64'(tl - hd));
        chk("full", stq_full_o, 64'((tl - hd) == 16));
        chk("empty", stq_empty_o, 64'(tl == hd));
        chk("gnt", alloc_gnt_o, 64'(exp_gnt()));
        chk("alloc_id", alloc_id_o, 64'(tl % 16));
        chk("raddr", ram_raddr_o, 64'(hd % 16));
        chk("dc_valid", dc.dc_req_valid_o, 64'(dph == 1));
        if (dph == 1) chk("dc_data", dc.dc_req_data_o, dexp);
        chk("ram_we", ram_we_o, 64'(m_we));
        if (m_we) begin
            chk("ram_waddr", ram_waddr_o, 64'(m_waddr));
            chk("ram_wdata", ram_wdata_o, m_wdata);
        end
    endtask

    task automatic model_edge();
        bit g;
        int cm_n, tl_n, hd_n, dph_n;
        if (!reset) begin
            hd = 0; cm = 0; tl = 0; dph = 0; m_we = 0;
            foreach (rdy[i]) rdy[i] = 0;
            return;
        end
        g = exp_gnt();
        hd_n = hd; cm_n = cm; tl_n = tl; dph_n = dph;
        if (dph == 0) begin
            if (hd < cm && rdy[hd % 16]) begin
                dph_n = 1;
                dexp  = pay[hd % 16];
            end
        end else if (dph == 1) begin
            if (dc.dc_req_ready_i) dph_n = 2;
        end else if (dc.dc_ack_i) begin
            dph_n = 0;
            hd_n = hd + 1;
            rdy[hd % 16] = 0;
        end
        if (commit_i && cm < tl) cm_n = cm + 1;
        if (flush_i) tl_n = cm_n;
        else if (recover_i) tl_n = cm + ((int'(recover_tail_i) - cm) & 31);
        else if (g) begin
            tl_n = tl + 1;
            rdy[tl % 16] = 0;
        end
        if (wr_valid_i) begin
            rdy[wr_id_i] = 1;
            pay[wr_id_i] = wr_data_i;
        end
        m_we = wr_valid_i; m_waddr = wr_id_i; m_wdata = wr_data_i;
        hd = hd_n; cm = cm_n; tl = tl_n; dph = dph_n;
    endtask

    task automatic step(input bit c = 1'b1);
        #1;
        if (c) check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        alloc_req_i = 0; wr_valid_i = 0; commit_i = 0;
        recover_i = 0; flush_i = 0;
        dc.dc_req_ready_i = 0; dc.dc_ack_i = 0;
    endtask

    task automatic reset_dut();
        reset = 0; step(); step(); reset = 1;
    endtask

    task automatic drain_one(input string tag, input logic [63:0] d);
        int n = 0;
        while (dc.dc_req_valid_o !== 1'b1 && n < 20) begin step(); n++; end
        #1;
        chk({tag, "_valid"}, dc.dc_req_valid_o, 1);
        chk({tag, "_data"}, dc.dc_req_data_o, d);
        dc.dc_req_ready_i = 1; step();
        dc.dc_ack_i = 1; step();
    endtask

    initial begin
        logic [63:0] d0, d1;
        int n;
        reset = 0; alloc_req_i = 0; wr_valid_i = 0; wr_id_i = 0;
        wr_data_i = 0; commit_i = 0; recover_i = 0; recover_tail_i = 0;
        flush_i = 0; dc.dc_req_ready_i = 0; dc.dc_ack_i = 0;
        hd = 0; cm = 0; tl = 0; dph = 0; m_we = 0; dexp = 0;

        // Reset state
        step(0); step(0); reset = 1;
        #1;
        chk("rst_empty", stq_empty_o, 1);
        chk("rst_count", stq_count_o, 0);
        chk("rst_full", stq_full_o, 0);
        chk("rst_valid", dc.dc_req_valid_o, 0);
        chk("rst_we", ram_we_o, 0);
        chk("rst_raddr", ram_raddr_o, 0);

        // Fill, overflow, drain one while full
        for (int i = 0; i < 16; i++) begin
            alloc_req_i = 1; #1;
            chk("fill_id", alloc_id_o, 64'(i));
            chk("fill_gnt", alloc_gnt_o, 1);
            step();
        end
        #1; chk("fill_full", stq_full_o, 1);
        alloc_req_i = 1; #1; chk("over_gnt", alloc_gnt_o, 0); step();
        d0 = 64'h0123_4567_89ab_cdef;
        alloc_req_i = 1; wr_valid_i = 1; wr_id_i = 0; wr_data_i = d0; step();
        alloc_req_i = 1; commit_i = 1; step();
        alloc_req_i = 1; step();
        alloc_req_i = 1; dc.dc_req_ready_i = 1; #1;
        chk("full_drain_data", dc.dc_req_data_o, d0);
        step();
        alloc_req_i = 1; dc.dc_ack_i = 1; #1;
        chk("ack_cycle_gnt", alloc_gnt_o, 0); step();
        alloc_req_i = 1; #1;
        chk("post_ack_gnt", alloc_gnt_o, 1);
        chk("post_ack_id", alloc_id_o, 0);
        step();

        // Writeback latency and drain ordering
        reset_dut();
        repeat (3) begin alloc_req_i = 1; step(); end
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
        wr_valid_i = 1; wr_id_i = 1; wr_data_i = d1; step();
        #1;
        chk("wb_we", ram_we_o, 1);
        chk("wb_waddr", ram_waddr_o, 1);
        chk("wb_wdata", ram_wdata_o, d1);
        commit_i = 1; step();
        commit_i = 1; step();
        repeat (4) begin
            dc.dc_req_ready_i = 1; #1;
            chk("wait_id0", dc.dc_req_valid_o, 0); step();
        end
        wr_valid_i = 1; wr_id_i = 0; wr_data_i = d0; step();
        drain_one("order0", d0);
        drain_one("order1", d1);

        // Back-pressure hold and ack spacing
        reset_dut();
        alloc_req_i = 1; step(); alloc_req_i = 1; step();
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
        wr_valid_i = 1; wr_id_i = 0; wr_data_i = d0; commit_i = 1; step();
        wr_valid_i = 1; wr_id_i = 1; wr_data_i = d1; commit_i = 1; step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_valid", dc.dc_req_valid_o, 1);
            chk("hold_data", dc.dc_req_data_o, d0);
            step();
        end
        dc.dc_req_ready_i = 1; step();
        step(); step();
        #1; chk("pre_ack_count", stq_count_o, 2);
        dc.dc_ack_i = 1; step();
        #1;
        chk("ack_head_count", stq_count_o, 1);
        chk("ack_gap_valid", dc.dc_req_valid_o, 0);
        step();
        #1;
        chk("next_valid", dc.dc_req_valid_o, 1);
        chk("next_data", dc.dc_req_data_o, d1);
        dc.dc_req_ready_i = 1; step();
        dc.dc_ack_i = 1; step();

        // Wrap, then commit+recover and commit+flush with alloc
        reset_dut();
        for (int i = 0; i < 16; i++) begin alloc_req_i = 1; step(); end
        for (int i = 0; i < 16; i++) begin
            wr_valid_i = 1; wr_id_i = 4'(i); wr_data_i = {$urandom, $urandom};
            commit_i = 1; step();
        end
        n = 0;
        while (stq_empty_o !== 1'b1 && n < 60) begin
            dc.dc_req_ready_i = 1; dc.dc_ack_i = 1; step(); n++;
        end
        chk("wrap_drained", stq_empty_o, 1);
        repeat (12) begin alloc_req_i = 1; step(); end
        repeat (10) begin commit_i = 1; step(); end
        #1; chk("wrap_count", stq_count_o, 12);
        commit_i = 1; recover_i = 1; recover_tail_i = 5'b11011;
        alloc_req_i = 1; #1;
        chk("rec_gnt", alloc_gnt_o, 0); step();
        #1; chk("rec_count", stq_count_o, 11);
        alloc_req_i = 1; step(); alloc_req_i = 1; step();
        commit_i = 1; flush_i = 1; alloc_req_i = 1; #1;
        chk("flush_gnt", alloc_gnt_o, 0); step();
        #1; chk("flush_count", stq_count_o, 12);
        commit_i = 1; step();
        #1; chk("flush_cmt_eq_tail", stq_count_o, 12);

        // Reset while waiting for the D-cache ack
        reset_dut();
        alloc_req_i = 1; step();
        wr_valid_i = 1; wr_id_i = 0; wr_data_i = {$urandom, $urandom};
        commit_i = 1; step();
        n = 0;
        while (dc.dc_req_valid_o !== 1'b1 && n < 20) begin step(); n++; end
        chk("rw_valid", dc.dc_req_valid_o, 1);
        dc.dc_req_ready_i = 1; step();
        reset = 0; step(); reset = 1;
        dc.dc_ack_i = 1; step();
        #1;
        chk("rw_count", stq_count_o, 0);
        chk("rw_raddr", ram_raddr_o, 0);
        chk("rw_valid0", dc.dc_req_valid_o, 0);
        step(); step();

        // Randomized traffic
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            alloc_req_i = ($urandom_range(0, 3) != 0);
            if (tl > hd && $urandom_range(0, 2) == 0) begin
                int off;
                off = int'($urandom_range(0, tl - hd - 1));
                if (!(off == 0 && dph != 0)) begin
                    wr_valid_i = 1;
                    wr_id_i = 4'((hd + off) % 16);
                    wr_data_i = {$urandom, $urandom};
                end
            end
            commit_i = ($urandom_range(0, 2) == 0);
            flush_i = ($urandom_range(0, 29) == 0);
            if (!flush_i && $urandom_range(0, 19) == 0) begin
                recover_i = 1;
                recover_tail_i = 5'((cm + int'($urandom_range(0, tl - cm))) % 32);
            end
            dc.dc_req_ready_i = ($urandom_range(0, 1) == 0);
            dc.dc_ack_i = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
